serial_add_ctrl: RTL and testbench

Multi-cycle controller that sequences a single 1-bit full-adder slice across a WIDTH-bit operand pair, LSB first, one bit per clock. It accepts operands through a valid/ready input handshake and returns the sum and carry-out through a valid/ready output handshake. It is the area-minimal counterpart to the combinational ripple adder and is intended for use as a shared arithmetic resource behind the lab datapath. An optional subtract mode reuses the same slice.

---
 rtl/serial_add_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder/subtractor controller. One full-adder slice
//               is stepped across a WIDTH-bit operand pair, LSB first, one bit
//               per clock. Operands arrive via a valid/ready handshake and the
//               sum/carry-out leave via a second valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // Bit counter only needs to reach WIDTH-1; keep at least one bit.
    localparam int              CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q,   opa_d;
    logic [WIDTH-1:0] opb_q,   opb_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;

    logic w_accept;
    logic w_run;
    logic w_last;
    logic w_bit_s;
    logic w_bit_c;

    // Handshake / progress qualifiers derived from the current state.
    assign w_accept = in_valid && (state_q == c_ST_IDLE);
    assign w_run    = (state_q == c_ST_RUN);
    assign w_last   = w_run && (cnt_q == c_CNT_LAST);

    // The single full-adder slice working on the current LSBs.
    assign w_bit_s = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign w_bit_c = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: accept in IDLE, step WIDTH bits in RUN, wait for consumer in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (w_accept)  state_d = c_ST_RUN;
            c_ST_RUN:  if (w_last)    state_d = c_ST_DONE;
            c_ST_DONE: if (out_ready) state_d = c_ST_IDLE;
            default:                  state_d = c_ST_IDLE;
        endcase
    end

    // FSM outputs: handshake flags decoded from state, results straight from registers.
    always_comb begin
        in_ready  = (state_q == c_ST_IDLE);
        out_valid = (state_q == c_ST_DONE);
        busy      = (state_q != c_ST_IDLE);
        sum       = sum_q;
        cout      = cout_q;
    end

    // Datapath next values: capture on accept, shift one bit per RUN cycle, hold otherwise.
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (w_accept) begin
            // Subtraction is A + ~B + ~borrow_in, so invert B and the incoming carry here.
            opa_d   = a;
            opb_d   = sub ? ~b : b;
            carry_d = sub ? ~cin : cin;
            cnt_d   = '0;
        end else if (w_run) begin
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            sum_d   = {w_bit_s, sum_q[WIDTH-1:1]};
            carry_d = w_bit_c;
            // Counter parks on the last index instead of wrapping.
            cnt_d   = w_last ? cnt_q : (cnt_q + c_CNT_ONE);
            if (w_last) begin
                cout_d = w_bit_c;
            end
        end
    end

    // Datapath registers; reset clears everything so an aborted operation leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Scoreboard bench for serial_add_ctrl. Directed vectors on a
//               4-bit instance, a carry-boundary and model-checked back-to-back
//               operations on an 8-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    logic clk;
    logic rst_n;

    // 4-bit instance
    logic       in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0] a4, b4, sum4;
    // 8-bit instance
    logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, busy8;
    logic [7:0] a8, b8, sum8;

    int checks;
    int errors;

    logic [4:0] q4[$];
    logic [8:0] q8[$];

    serial_add_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
        .out_ready(out_ready4), .sum(sum4), .cout(cout4), .busy(busy4)
    );

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .cout(cout8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Result monitors: a result is consumed when out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                chk("sb4_unexpected", {27'd0, cout4, sum4}, 32'hFFFF_FFFF);
            end else begin
                chk("sb4_result", {27'd0, cout4, sum4}, {27'd0, q4.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                chk("sb8_unexpected", {23'd0, cout8, sum8}, 32'hFFFF_FFFF);
            end else begin
                chk("sb8_result", {23'd0, cout8, sum8}, {23'd0, q8.pop_front()});
            end
        end
    end

    // One 4-bit operation: accept, check latency, optional backpressure, then hand off.
    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tcin,
                       input logic tsub, input logic [4:0] exp, input int hold);
        int lat;
        logic [3:0] held_sum;
        logic       held_cout;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready4}, 32'd1);
        a4 = ta; b4 = tb; cin4 = tcin; sub4 = tsub; in_valid4 = 1'b1;
        @(posedge clk);
        q4.push_back(exp);
        #1;
        in_valid4 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            // Scramble inputs while busy; captured operands must not change.
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
            in_valid4 = lat[0];
            @(negedge clk);
            if (!out_valid4) chk("in_ready_busy", {31'd0, in_ready4}, 32'd0);
        end while (!out_valid4 && lat < 20);
        chk("latency", lat, 32'd4);
        held_sum  = sum4;
        held_cout = cout4;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            a4 = 4'($urandom); in_valid4 = ~in_valid4;
            @(negedge clk);
            chk("bp_hold", {25'd0, out_valid4, in_ready4, cout4, sum4}, {25'd0, 1'b1, 1'b0, held_cout, held_sum});
        end
        @(posedge clk);
        #1;
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        @(negedge clk);
        chk("idle_after_out", {30'd0, in_ready4, out_valid4}, 32'd2);
    endtask

    // One 8-bit operation issued as soon as the block is ready; out_ready stays high.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                       input logic tsub, input logic [8:0] exp);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready8 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready8) chk("op8_timeout", 32'd0, 32'd1);
        a8 = ta; b8 = tb; cin8 = tcin; sub8 = tsub; in_valid8 = 1'b1;
        @(posedge clk);
        q8.push_back(exp);
        #1;
        in_valid8 = 1'b0;
    endtask

    function automatic logic [8:0] model8(input logic [7:0] ta, input logic [7:0] tb,
                                          input logic tcin, input logic tsub);
        logic [8:0] bb;
        logic [8:0] cc;
        bb = tsub ? {1'b0, ~tb} : {1'b0, tb};
        cc = {8'd0, tsub ? ~tcin : tcin};
        return {1'b0, ta} + bb + cc;
    endfunction

    initial begin
        int waited;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        in_valid4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0; out_ready4 = 0;
        in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; out_ready8 = 1;
        #2;
        chk("reset_state", {24'd0, in_ready4, busy4, out_valid4, cout4, sum4}, {24'd0, 8'b1000_0000});
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed add / subtract vectors, expected {cout,sum} worked by hand.
        op4(4'b0001, 4'b0100, 1'b0, 1'b0, 5'b0_0101, 0);
        op4(4'b1111, 4'b1111, 1'b1, 1'b0, 5'b1_1111, 0);
        op4(4'b1100, 4'b0011, 1'b0, 1'b0, 5'b0_1111, 10);
        op4(4'b1101, 4'b0011, 1'b1, 1'b0, 5'b1_0001, 0);
        op4(4'b0101, 4'b0011, 1'b0, 1'b1, 5'b1_0010, 0);
        op4(4'b0011, 4'b0101, 1'b0, 1'b1, 5'b0_1110, 3);

        // Abort mid-RUN: reset clears everything before the next clock edge.
        @(negedge clk);
        a4 = 4'b1010; b4 = 4'b0101; cin4 = 0; sub4 = 0; in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {24'd0, in_ready4, busy4, out_valid4, cout4, sum4}, {24'd0, 8'b1000_0000});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        op4(4'b0110, 4'b0001, 1'b0, 1'b0, 5'b0_0111, 0);

        // 8-bit carry boundary, then back-to-back model-checked operations.
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic rc, rs;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            op8(ra, rb, rc, rs, model8(ra, rb, rc, rs));
        end

        waited = 0;
        while ((q8.size() != 0 || q4.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", q4.size() + q8.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
